// File: rtl/i2c_mst_ctrl_byte_if.sv
// i2c_mst_ctrl_byte_if
//   Bundles the signals around the I2C byte sequencer: the host request side
//   (start/stop/read/write/ack_in/din -> cmd_ack/ack_out/dout/i2c_al) and the
//   bit-controller side (core_cmd/core_txd -> core_ack/core_al/core_rxd).
//   slave  : the byte sequencer itself.
//   master : everything around it (host plus bit controller).
//   dbg_state exposes the sequencer FSM state for observation only.
//
// Handshake: the host raises start/read/write/stop (with ack_in/din) and holds
//   them steady until cmd_ack pulses for one cycle; a request is complete on
//   that pulse. Each core_cmd is held until core_ack pulses for one cycle; the
//   next command (or NOP) appears on the same edge that samples core_ack.
//   core_al aborts the request: no cmd_ack follows, i2c_al pulses instead.
interface i2c_mst_ctrl_byte_if #(
  parameter int NBITS = 8
);
  logic             start;
  logic             stop;
  logic             read;
  logic             write;
  logic             ack_in;
  logic [NBITS-1:0] din;
  logic             cmd_ack;
  logic             ack_out;
  logic [NBITS-1:0] dout;
  logic             i2c_al;
  logic [3:0]       core_cmd;
  logic             core_ack;
  logic             core_al;
  logic             core_txd;
  logic             core_rxd;
  logic [2:0]       dbg_state;

  modport slave (
    input  start, stop, read, write, ack_in, din,
    input  core_ack, core_al, core_rxd,
    output cmd_ack, ack_out, dout, i2c_al,
    output core_cmd, core_txd, dbg_state
  );

  modport master (
    output start, stop, read, write, ack_in, din,
    output core_ack, core_al, core_rxd,
    input  cmd_ack, ack_out, dout, i2c_al,
    input  core_cmd, core_txd, dbg_state
  );
endinterface

// File: rtl/i2c_mst_ctrl_byte.sv
// i2c_mst_ctrl_byte
//   Byte-level sequencer for the I2C master bit controller. Expands a host
//   byte request (optional START, one byte read or write plus the ACK bit,
//   optional STOP) into bit commands, issuing each one when the previous one
//   is acknowledged by the bit controller.
// Ports
//   clk   : system clock
//   rstn  : asynchronous active-low reset
//   bus   : i2c_mst_ctrl_byte_if.slave (host request side + bit-controller side)
// All outputs are registered.
module i2c_mst_ctrl_byte #(
  parameter int NBITS = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  i2c_mst_ctrl_byte_if.slave    bus
);

  localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;

  localparam logic [3:0] CMD_NOP   = 4'b0000;
  localparam logic [3:0] CMD_START = 4'b0001;
  localparam logic [3:0] CMD_STOP  = 4'b0010;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_READ  = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_ACK   = 3'd4,
    ST_STOP  = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic [NBITS-1:0] sreg, sreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [3:0]       core_cmd_q, core_cmd_nxt;
  logic             core_txd_q, core_txd_nxt;
  logic             cmd_ack_q, cmd_ack_nxt;
  logic             ack_out_q, ack_out_nxt;
  logic [NBITS-1:0] dout_q, dout_nxt;
  logic             i2c_al_q;
  logic             go;

  // cmd_ack masks go so the still-held request is not restarted in the
  // cycle the host sees completion.
  assign go = (bus.read | bus.write | bus.stop) & ~cmd_ack_q;

  function automatic logic [3:0] cmd_of(state_t s);
    case (s)
      ST_START: cmd_of = CMD_START;
      ST_READ:  cmd_of = CMD_READ;
      ST_WRITE: cmd_of = CMD_WRITE;
      ST_STOP:  cmd_of = CMD_STOP;
      default:  cmd_of = CMD_NOP;
    endcase
  endfunction

  // State and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      sreg       <= '0;
      cnt        <= '0;
      core_cmd_q <= CMD_NOP;
      core_txd_q <= 1'b0;
      cmd_ack_q  <= 1'b0;
      ack_out_q  <= 1'b0;
      dout_q     <= '0;
      i2c_al_q   <= 1'b0;
    end else begin
      state      <= state_nxt;
      sreg       <= sreg_nxt;
      cnt        <= cnt_nxt;
      core_cmd_q <= core_cmd_nxt;
      core_txd_q <= core_txd_nxt;
      cmd_ack_q  <= cmd_ack_nxt;
      ack_out_q  <= ack_out_nxt;
      dout_q     <= dout_nxt;
      i2c_al_q   <= bus.core_al;
    end
  end

  // Next state; arbitration loss overrides everything.
  always_comb begin
    state_nxt = state;
    if (bus.core_al) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:
          if (go) begin
            if (bus.start)      state_nxt = ST_START;
            else if (bus.read)  state_nxt = ST_READ;
            else if (bus.write) state_nxt = ST_WRITE;
            else                state_nxt = ST_STOP;
          end
        ST_START:
          if (bus.core_ack) begin
            if (bus.read)       state_nxt = ST_READ;
            else if (bus.write) state_nxt = ST_WRITE;
            else                state_nxt = ST_STOP;
          end
        ST_WRITE, ST_READ:
          if (bus.core_ack && cnt == '0) state_nxt = ST_ACK;
        ST_ACK:
          if (bus.core_ack) state_nxt = bus.stop ? ST_STOP : ST_IDLE;
        ST_STOP:
          if (bus.core_ack) state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    sreg_nxt     = sreg;
    cnt_nxt      = cnt;
    core_cmd_nxt = core_cmd_q;
    core_txd_nxt = core_txd_q;
    cmd_ack_nxt  = 1'b0;
    ack_out_nxt  = ack_out_q;
    dout_nxt     = dout_q;
    if (bus.core_al) begin
      core_cmd_nxt = CMD_NOP;
    end else begin
      case (state)
        ST_IDLE:
          if (go) begin
            sreg_nxt     = bus.din;
            cnt_nxt      = CW'(NBITS - 1);
            core_cmd_nxt = cmd_of(state_nxt);
            if (state_nxt == ST_WRITE) core_txd_nxt = bus.din[NBITS-1];
          end
        ST_START:
          if (bus.core_ack) begin
            core_cmd_nxt = cmd_of(state_nxt);
            if (state_nxt == ST_WRITE) core_txd_nxt = sreg[NBITS-1];
          end
        ST_WRITE:
          if (bus.core_ack) begin
            if (cnt == '0) begin
              core_cmd_nxt = CMD_READ;      // sample the slave ACK
            end else begin
              cnt_nxt      = cnt - CW'(1);
              sreg_nxt     = {sreg[NBITS-2:0], 1'b0};
              core_txd_nxt = sreg[NBITS-2];
            end
          end
        ST_READ:
          if (bus.core_ack) begin
            sreg_nxt = {sreg[NBITS-2:0], bus.core_rxd};
            if (cnt == '0) begin
              core_cmd_nxt = CMD_WRITE;     // drive our ACK/NACK
              core_txd_nxt = bus.ack_in;
            end else begin
              cnt_nxt = cnt - CW'(1);
            end
          end
        ST_ACK:
          if (bus.core_ack) begin
            ack_out_nxt = bus.core_rxd;
            dout_nxt    = sreg;
            if (bus.stop) begin
              core_cmd_nxt = CMD_STOP;
            end else begin
              core_cmd_nxt = CMD_NOP;
              cmd_ack_nxt  = 1'b1;
            end
          end
        ST_STOP:
          if (bus.core_ack) begin
            core_cmd_nxt = CMD_NOP;
            cmd_ack_nxt  = 1'b1;
          end
        default: core_cmd_nxt = CMD_NOP;
      endcase
    end
  end

  assign bus.core_cmd  = core_cmd_q;
  assign bus.core_txd  = core_txd_q;
  assign bus.cmd_ack   = cmd_ack_q;
  assign bus.ack_out   = ack_out_q;
  assign bus.dout      = dout_q;
  assign bus.i2c_al    = i2c_al_q;
  assign bus.dbg_state = state;

endmodule
